// File: rtl/arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// Holds the FSM state encoding and the counter-width calculation.
package arb_pkg;

   typedef enum logic {S_CORE, S_HOST} arb_state_t;

   // Wide enough to hold either limit without wrapping.
   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/arb_cnt.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
// Holds at Limit instead of wrapping.
module arb_cnt #(
   parameter int unsigned Width = 3,
   parameter int unsigned Limit = 4
) (
   input  logic             clk_i,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [Width-1:0] cnt_o
);

   localparam logic [Width-1:0] LimitVal = Width'(Limit);

   logic [Width-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q < LimitVal)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// Core-priority arbiter for the single-port data RAM, shared with a host port.
// The host gets idle core cycles, or a bounded forced burst that stalls the core.
module mem_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned DW        = 32,
   parameter int unsigned AW        = 32,
   parameter int unsigned MAX_WAIT  = 4,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          core_req,
   input  logic          core_memWrite,
   input  logic [AW-1:0] core_memAddr,
   input  logic [DW-1:0] core_wrData,
   output logic [DW-1:0] core_memData,
   output logic          core_stall,
   input  logic          host_req,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdata,
   output logic          host_gnt,
   output logic [DW-1:0] host_rdata,
   output logic          host_rvalid,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata
);

   localparam int unsigned CW        = cnt_width(MAX_WAIT, MAX_BURST);
   localparam logic [CW-1:0] WaitLast  = CW'(MAX_WAIT - 1);
   localparam logic [CW-1:0] BurstLast = CW'(MAX_BURST - 1);

   arb_state_t    state_q, state_d;
   logic [CW-1:0] wait_cnt, burst_cnt;
   logic          wait_clr, wait_en, burst_clr, burst_en;
   logic          host_sel, gnt_raw, stall_raw, we_raw;
   logic          rd_fire;
   logic          host_rvalid_q;
   logic [DW-1:0] host_rdata_q, host_rdata_d;

   arb_cnt #(
      .Width (CW),
      .Limit (MAX_WAIT)
   ) u_wait_cnt (
      .clk_i (clk),
      .clr_i (wait_clr),
      .en_i  (wait_en),
      .cnt_o (wait_cnt)
   );

   arb_cnt #(
      .Width (CW),
      .Limit (MAX_BURST)
   ) u_burst_cnt (
      .clk_i (clk),
      .clr_i (burst_clr),
      .en_i  (burst_en),
      .cnt_o (burst_cnt)
   );

   always_comb begin
      state_d   = state_q;
      host_sel  = 1'b0;
      gnt_raw   = 1'b0;
      stall_raw = 1'b0;
      we_raw    = 1'b0;
      wait_en   = 1'b0;
      wait_clr  = 1'b0;
      burst_en  = 1'b0;
      burst_clr = 1'b0;
      unique case (state_q)
         S_CORE: begin
            burst_clr = 1'b1;
            if (host_req && !core_req) begin
               host_sel = 1'b1;
               gnt_raw  = 1'b1;
               we_raw   = host_we;
               wait_clr = 1'b1;
            end else begin
               we_raw = core_req & core_memWrite;
               if (host_req) begin
                  wait_en = 1'b1;
                  if (wait_cnt == WaitLast) begin
                     state_d  = S_HOST;
                     wait_clr = 1'b1;
                  end
               end else begin
                  wait_clr = 1'b1;
               end
            end
         end
         S_HOST: begin
            host_sel  = 1'b1;
            gnt_raw   = host_req;
            we_raw    = host_req & host_we;
            stall_raw = core_req;
            wait_clr  = 1'b1;
            if (!host_req) begin
               state_d   = S_CORE;
               burst_clr = 1'b1;
            end else if (core_req) begin
               burst_en = 1'b1;
               // Exit after the grant that uses up the burst budget.
               if (burst_cnt == BurstLast) begin
                  state_d   = S_CORE;
                  burst_clr = 1'b1;
               end
            end
         end
      endcase
      if (reset) begin
         state_d   = S_CORE;
         wait_clr  = 1'b1;
         burst_clr = 1'b1;
      end
   end

   // Reset masks every side effect so a reset cycle never touches the RAM.
   assign host_gnt   = gnt_raw & ~reset;
   assign core_stall = stall_raw & ~reset;
   assign ram_we     = we_raw & ~reset;
   assign ram_addr   = host_sel ? host_addr : core_memAddr;
   assign ram_wdata  = host_sel ? host_wdata : core_wrData;

   assign core_memData = ram_rdata;

   assign rd_fire      = host_gnt & ~host_we;
   assign host_rdata_d = rd_fire ? ram_rdata : host_rdata_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_CORE;
         host_rvalid_q <= 1'b0;
         host_rdata_q  <= '0;
      end else begin
         state_q       <= state_d;
         host_rvalid_q <= rd_fire;
         host_rdata_q  <= host_rdata_d;
      end
   end

   assign host_rvalid = host_rvalid_q;
   assign host_rdata  = host_rdata_q;

endmodule
